scroll_message_scheduler: RTL and testbench

Sequences the scrolling seven-segment display. It arbitrates between four message sources (normal score line, debug apple-location line, one-shot banner, game-over prompt) and generates the scroll step tick and character position from the main clock. Its outputs are a message select and a scroll restart pulse. It sits between the game-state logic and the scoreboard text/slider datapath. It replaces the screen-clock-domain state-change detection, so the whole display path runs on one clock.

---
 rtl/display_pkg.sv | 14 +
 rtl/scroll_step_gen.sv | 53 +++++
 rtl/scroll_message_scheduler.sv | 114 +++++++++++
 tb/tb_scroll_message_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Message-select encoding shared by the scroll scheduler and the scoreboard text mux.
// Pure definitions: no logic, no latency, no flow control.
package display_pkg;

  typedef enum logic [1:0] {
    MSG_NORMAL   = 2'd0,
    MSG_DEBUG    = 2'd1,
    MSG_BANNER   = 2'd2,
    MSG_GAMEOVER = 2'd3
  } msg_sel_t;

  localparam int MSG_COUNT = 4;

endpackage

// File: rtl/scroll_step_gen.sv
// Scroll step tick divider and character position counter with synchronous clear.
// Registered outputs, clear takes effect on the next edge; free-running, no backpressure.
module scroll_step_gen #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int MSG_CHARS = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  output logic                         scrollTick,
  output logic [$clog2(MSG_CHARS)-1:0] scrollPos,
  output logic                         passEnd
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int POS_W  = $clog2(MSG_CHARS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(MSG_CHARS - 1);

  logic [TICK_W-1:0] tickCnt;
  logic [TICK_W-1:0] tickNext;
  logic [POS_W-1:0]  posNext;

  always_comb begin
    tickNext = '0;
    posNext  = scrollPos;
    if (clear) begin
      tickNext = '0;
      posNext  = '0;
    end else begin
      tickNext = (tickCnt == TICK_LAST) ? '0 : tickCnt + TICK_W'(1);
      if (scrollTick) begin
        posNext = (scrollPos == POS_LAST) ? '0 : scrollPos + POS_W'(1);
      end
    end
  end

  // scrollTick is registered from the next count so it lines up with tickCnt == TICK_LAST.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tickCnt    <= '0;
      scrollPos  <= '0;
      scrollTick <= 1'b0;
    end else begin
      tickCnt    <= tickNext;
      scrollPos  <= posNext;
      scrollTick <= (tickNext == TICK_LAST);
    end
  end

  assign passEnd = scrollTick && (scrollPos == POS_LAST);

endmodule

// File: rtl/scroll_message_scheduler.sv
// Arbitrates the four display messages and drives scroll tick, position and restart.
// All outputs registered, one cycle from input to msgSel; no backpressure.
module scroll_message_scheduler
  import display_pkg::*;
#(
  parameter int TICK_DIV      = 12_500_000,
  parameter int MSG_CHARS     = 20,
  parameter int BANNER_PASSES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         gameOver,
  input  logic                         debugMode,
  input  logic                         bannerReq,
  output logic [1:0]                   msgSel,
  output logic                         scrollTick,
  output logic [$clog2(MSG_CHARS)-1:0] scrollPos,
  output logic                         scrollRestart,
  output logic                         bannerPending
);

  localparam int PASS_W = $clog2(BANNER_PASSES + 1);
  localparam logic [PASS_W-1:0] PASS_LOAD = PASS_W'(BANNER_PASSES);
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

  msg_sel_t          state;
  msg_sel_t          nextState;
  msg_sel_t          desired;
  logic [PASS_W-1:0] passCnt;
  logic [PASS_W-1:0] passCntNext;
  logic              pendingNext;
  logic              restartNext;
  logic              stepClear;
  logic              passEnd;
  logic              lastPass;

  scroll_step_gen #(
    .TICK_DIV  (TICK_DIV),
    .MSG_CHARS (MSG_CHARS)
  ) uStep (
    .clock      (clock),
    .reset      (reset),
    .clear      (stepClear),
    .scrollTick (scrollTick),
    .scrollPos  (scrollPos),
    .passEnd    (passEnd)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= MSG_NORMAL;
      passCnt       <= '0;
      bannerPending <= 1'b0;
      scrollRestart <= 1'b0;
    end else begin
      state         <= nextState;
      passCnt       <= passCntNext;
      bannerPending <= pendingNext;
      scrollRestart <= restartNext;
    end
  end

  always_comb begin
    if (gameOver) begin
      desired = MSG_GAMEOVER;
    end else if (bannerPending || bannerReq) begin
      desired = MSG_BANNER;
    end else if (debugMode) begin
      desired = MSG_DEBUG;
    end else begin
      desired = MSG_NORMAL;
    end

    lastPass  = passEnd && (passCnt <= PASS_ONE);
    nextState = state;
    // Game over preempts mid-pass; everything else waits for the pass to finish.
    if (gameOver) begin
      nextState = MSG_GAMEOVER;
    end else begin
      case (state)
        MSG_GAMEOVER: nextState = desired;
        MSG_BANNER:   if (lastPass) nextState = desired;
        default:      if (passEnd) nextState = desired;
      endcase
    end
  end

  always_comb begin
    restartNext = (nextState != state);
    stepClear   = restartNext;

    pendingNext = bannerPending;
    if (gameOver) begin
      pendingNext = 1'b0;
    end else if ((nextState == MSG_BANNER) && (state != MSG_BANNER)) begin
      pendingNext = 1'b0;
    end else if (bannerReq && (state != MSG_BANNER)) begin
      pendingNext = 1'b1;
    end

    // A request while the banner is already up extends it rather than queueing another.
    passCntNext = passCnt;
    if (nextState != MSG_BANNER) begin
      passCntNext = '0;
    end else if ((state != MSG_BANNER) || bannerReq) begin
      passCntNext = PASS_LOAD;
    end else if (passEnd) begin
      passCntNext = passCnt - PASS_ONE;
    end
  end

  assign msgSel = state;

endmodule

// File: tb/tb_scroll_message_scheduler.sv
// Directed scenarios for the scroll scheduler with a queued expected-output scoreboard.
`timescale 1ns/1ps
module tb_scroll_message_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       gameOver = 1'b0;
  logic       debugMode = 1'b0;
  logic       bannerReq = 1'b0;
  logic [1:0] msgSel;
  logic       scrollTick;
  logic [2:0] scrollPos;
  logic       scrollRestart;
  logic       bannerPending;

  typedef struct {
    string tag;
    int    cyc;
    int    sel;
    int    tick;
    int    pos;
    int    rs;
    int    pd;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  scroll_message_scheduler #(
    .TICK_DIV      (4),
    .MSG_CHARS     (5),
    .BANNER_PASSES (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .gameOver      (gameOver),
    .debugMode     (debugMode),
    .bannerReq     (bannerReq),
    .msgSel        (msgSel),
    .scrollTick    (scrollTick),
    .scrollPos     (scrollPos),
    .scrollRestart (scrollRestart),
    .bannerPending (bannerPending)
  );

  always #5 clock = ~clock;

  task automatic pushExp(string tag, int cyc, int sel, bit tick, int pos, bit rs, bit pd);
    exp_t e;
    e.tag  = tag;
    e.cyc  = cyc;
    e.sel  = sel;
    e.tick = int'(tick);
    e.pos  = pos;
    e.rs   = int'(rs);
    e.pd   = int'(pd);
    sbQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Free-running step pattern relative to the cycle o where counters were last zeroed.
  function automatic bit tk(int c, int o);
    return ((c - o) % 4) == 3;
  endfunction

  function automatic int ps(int c, int o);
    return ((c - o) / 4) % 5;
  endfunction

  task automatic cmpField(string tag, int cyc, string field, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d %s: got %0d want %0d", tag, cyc, field, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      cmpField(e.tag, e.cyc, "msgSel",        int'(msgSel),        e.sel);
      cmpField(e.tag, e.cyc, "scrollTick",    int'(scrollTick),    e.tick);
      cmpField(e.tag, e.cyc, "scrollPos",     int'(scrollPos),     e.pos);
      cmpField(e.tag, e.cyc, "scrollRestart", int'(scrollRestart), e.rs);
      cmpField(e.tag, e.cyc, "bannerPending", int'(bannerPending), e.pd);
    end
  end

  task automatic doReset();
    reset     = 1'b0;
    gameOver  = 1'b0;
    debugMode = 1'b0;
    bannerReq = 1'b0;
    pushExp("in_reset", -1, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel;
    int o;

    doReset();
    for (int c = 0; c <= 44; c++) begin
      pushExp("idle", c, 0, tk(c, 0), ps(c, 0), 0, 0);
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 44; c++) begin
      if (c == 7) debugMode = 1'b1;
      if (c < 20) pushExp("debug", c, 0, tk(c, 0), ps(c, 0), 0, 0);
      else        pushExp("debug", c, 1, tk(c, 20), ps(c, 20), c == 20, 0);
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 64; c++) begin
      bannerReq = (c == 3);
      sel = (c < 20) ? 0 : (c < 60) ? 2 : 0;
      o   = (c < 20) ? 0 : (c < 60) ? 20 : 60;
      pushExp("banner", c, sel, tk(c, o), ps(c, o), (c == 20) || (c == 60), (c >= 4) && (c < 20));
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 84; c++) begin
      bannerReq = (c == 3) || (c == 45);
      debugMode = (c >= 25);
      sel = (c < 20) ? 0 : (c < 80) ? 2 : 1;
      o   = (c < 20) ? 0 : (c < 80) ? 20 : 80;
      pushExp("banner_reload", c, sel, tk(c, o), ps(c, o), (c == 20) || (c == 80), (c >= 4) && (c < 20));
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 56; c++) begin
      bannerReq = (c == 3) || (c == 40);
      gameOver  = (c >= 29) && (c < 49);
      sel = (c < 20) ? 0 : (c < 30) ? 2 : (c < 50) ? 3 : 0;
      o   = (c < 20) ? 0 : (c < 30) ? 20 : (c < 50) ? 30 : 50;
      pushExp("gameover", c, sel, tk(c, o), ps(c, o), (c == 20) || (c == 30) || (c == 50), (c >= 4) && (c < 20));
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 29; c++) begin
      gameOver  = (c >= 19);
      bannerReq = (c == 19);
      sel = (c < 20) ? 0 : 3;
      o   = (c < 20) ? 0 : 20;
      pushExp("go_at_passend", c, sel, tk(c, o), ps(c, o), c == 20, 0);
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 29; c++) begin
      bannerReq = (c == 19);
      sel = (c < 20) ? 0 : 2;
      o   = (c < 20) ? 0 : 20;
      pushExp("banner_at_passend", c, sel, tk(c, o), ps(c, o), c == 20, 0);
      nextCycle();
    end

    doReset();
    for (int c = 0; c <= 32; c++) begin
      debugMode = 1'b1;
      sel = (c < 20) ? 0 : 1;
      o   = (c < 20) ? 0 : 20;
      pushExp("pre_rst", c, sel, tk(c, o), ps(c, o), c == 20, 0);
      nextCycle();
    end
    reset     = 1'b0;
    debugMode = 1'b0;
    pushExp("async_rst", 33, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      pushExp("post_rst", c, 0, tk(c, 0), ps(c, 0), 0, 0);
      nextCycle();
    end

    nextCycle();
    nextCycle();
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries want 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
